end_screen_fade_ctrl: RTL and testbench
=======================================

Name: end_screen_fade_ctrl

Overview:
Sequences the end-of-game screen. Passes per-pixel sprite indices to the 16-entry end-screen palette ROM and scales the returned 4-bit RGB by a frame-stepped fade level. Runs fade-in, a timed hold, a show phase that waits for restart, and fade-out. Sits between the end-screen sprite ROM address logic and the VGA colour mux.

Parameters:
FADE_STEP_FRAMES, 4, frame_tick pulses per fade-level step (legal 1..255)
HOLD_FRAMES, 180, frame_tick pulses in HOLD before restart is accepted (legal 0..1023; 0 = HOLD lasts 1 cycle)

Ports:
clk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
frame_tick  in  1  1-cycle pulse per frame (vsync start)
game_over  in  1  level; requests the end screen
restart  in  1  1-cycle pulse from user input
pix_valid  in  1  pixel inside end-screen sprite region
pix_index  in  4  sprite palette index for current pixel
pal_index  out  4  index to palette ROM (combinational = pix_index)
pal_red, pal_green, pal_blue  in  4 each  palette ROM output (combinational)
red, green, blue  out  4 each  faded colour, registered
rgb_valid  out  1  red/green/blue valid this cycle
transparent  out  1  pixel is key colour (feature-gated)
active  out  1  end screen visible (state != IDLE/DONE)
fade_level  out  4  current level 0..15
done  out  1  1-cycle pulse when fade-out completes

Behaviour:
- Reset (async, rst_n=0): state=IDLE; fade_level=0; frame and hold counters=0; red/green/blue=0; rgb_valid=0; transparent=0; active=0; done=0. Reset mid-fade aborts immediately. After release, IDLE is entered with no residual level.
- States:
  - IDLE: game_over=1 → FADE_IN.
  - FADE_IN: step counter counts frame_tick. When it reaches FADE_STEP_FRAMES, fade_level++ and the counter clears. On fade_level reaching 15 → HOLD with the hold counter cleared.
  - HOLD: counts frame_tick. When the count reaches HOLD_FRAMES → SHOW.
  - SHOW: restart=1 → FADE_OUT.
  - FADE_OUT: same stepping as FADE_IN, decrementing. On reaching 0 → DONE with done=1 for exactly that transition cycle.
  - DONE: stays until game_over=0, then → IDLE. This prevents re-trigger.
- restart is ignored in every state except SHOW.
- game_over deassertion is ignored except in DONE.
- frame_tick and restart in the same SHOW cycle: transition is taken and the tick is not counted.
- Counter saturation: fade_level never wraps. No increment above 15, no decrement below 0.
- Pixel pipeline, latency 1 cycle:
  - pal_index = pix_index (combinational).
  - Registered: rgb_valid <= pix_valid & active.
  - Each channel <= ((pal_c * (fade_level+1)) >> 4), 8-bit product, upper nibble kept, using the fade_level of the same cycle.
  - level 15 yields pal_c unchanged; level 0 yields 0 for all inputs.
  - When rgb_valid would be 0, red/green/blue register 0.
- fade_level output updates on the step cycle; the pixel path sees the new level from the next pixel onward.

Optional Feature:
TRANSPARENT_KEY_EN
- Defined: pal_index==0 with pix_valid&active registers transparent=1 and red/green/blue=0; rgb_valid stays 1.
- Undefined: transparent is constant 0; index 0 is scaled like any other entry.

Test Plan:
1. FADE_STEP_FRAMES=2, HOLD_FRAMES=3; reset, game_over=1, 30 frame_ticks → fade_level steps every 2 ticks, reaches 15 on tick 30, state HOLD; 3 further ticks → SHOW.
2. At fade_level=7, pix_valid=1, palette returns (F,F,F) → next cycle red/green/blue=(7,7,7), rgb_valid=1. At level 15, palette (E,F,F) → (E,F,F). At level 0 → (0,0,0).
3. restart pulses during FADE_IN and HOLD → ignored. restart in SHOW → FADE_OUT; 30 ticks → level 0, done=1 for one cycle; game_over held 1 → stays DONE, active=0; game_over=0 → IDLE.
4. rst_n=0 at fade_level=9 mid FADE_OUT → all outputs 0 within the reset assertion, with no clock required. Release with game_over=1 → fresh FADE_IN from level 0.
5. TRANSPARENT_KEY_EN defined, pix_index=0, palette (F,0,B), level 15 → transparent=1, rgb=(0,0,0). Undefined build → transparent=0, rgb=(F,0,B).
6. frame_tick coincident with restart in SHOW → FADE_OUT entered. The first decrement occurs after FADE_STEP_FRAMES subsequent ticks, not counting the coincident tick.

Source files
------------

// File: rtl/end_screen_fade_ctrl.sv
// End-of-game screen sequencer: fade-in, hold, show-until-restart, fade-out, with a faded palette pixel path.
// Optional transparent key colour (palette index 0) enabled by defining TRANSPARENT_KEY_EN.
module end_screen_fade_ctrl #(
  parameter int unsigned FADE_STEP_FRAMES = 4,
  parameter int unsigned HOLD_FRAMES      = 180
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       game_over,
  input  logic       restart,
  input  logic       pix_valid,
  input  logic [3:0] pix_index,
  output logic [3:0] pal_index,
  input  logic [3:0] pal_red,
  input  logic [3:0] pal_green,
  input  logic [3:0] pal_blue,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue,
  output logic       rgb_valid,
  output logic       transparent,
  output logic       active,
  output logic [3:0] fade_level,
  output logic       done
);

  localparam int unsigned LVL_W  = 4;
  localparam int unsigned STEP_W = 8;
  localparam int unsigned HOLD_W = 10;

  localparam logic [LVL_W-1:0]  LVL_MAX   = LVL_W'(15);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(FADE_STEP_FRAMES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_FRAMES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FADE_IN,
    S_HOLD,
    S_SHOW,
    S_FADE_OUT,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              done_q, done_d;
  logic              active_q, active_d;

  logic              rgb_valid_q;
  logic              transparent_q;
  logic [3:0]        red_q, green_q, blue_q;

  // Upper nibble of channel * (level + 1); level 15 passes the colour through, level 0 blanks it.
  function automatic logic [3:0] scale_ch(input logic [3:0] c, input logic [7:0] m);
    logic [7:0] p;
    p = 8'(c) * m;
    return p[7:4];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      level_q  <= '0;
      step_q   <= '0;
      hold_q   <= '0;
      done_q   <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      step_q   <= step_d;
      hold_q   <= hold_d;
      done_q   <= done_d;
      active_q <= active_d;
    end
  end

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    step_d  = step_q;
    hold_d  = hold_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (game_over) begin
          state_d = S_FADE_IN;
          level_d = '0;
          step_d  = '0;
        end
      end
      S_FADE_IN: begin
        if (frame_tick) begin
          if (step_q == STEP_LAST) begin
            step_d = '0;
            if (level_q != LVL_MAX) level_d = level_q + LVL_W'(1);
            if (level_d == LVL_MAX) begin
              state_d = S_HOLD;
              hold_d  = '0;
            end
          end else begin
            step_d = step_q + STEP_W'(1);
          end
        end
      end
      S_HOLD: begin
        if (hold_q == HOLD_LAST) begin
          state_d = S_SHOW;
        end else if (frame_tick) begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      S_SHOW: begin
        // A tick arriving with restart is dropped so fade-out starts from a clean step count.
        if (restart) begin
          state_d = S_FADE_OUT;
          step_d  = '0;
        end
      end
      S_FADE_OUT: begin
        if (frame_tick) begin
          if (step_q == STEP_LAST) begin
            step_d = '0;
            if (level_q != '0) level_d = level_q - LVL_W'(1);
            if (level_d == '0) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end
          end else begin
            step_d = step_q + STEP_W'(1);
          end
        end
      end
      S_DONE: begin
        if (!game_over) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    active_d = (state_d != S_IDLE) && (state_d != S_DONE);
  end

  logic       pix_vld_c;
  logic       key_c;
  logic [7:0] mult_c;

  assign pix_vld_c = pix_valid & active_q;
  assign mult_c    = 8'(level_q) + 8'd1;
`ifdef TRANSPARENT_KEY_EN
  assign key_c     = pix_vld_c & (pix_index == 4'd0);
`else
  assign key_c     = 1'b0;
`endif

  // One-cycle pixel stage: colour is forced to zero when invalid or keyed out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_valid_q   <= 1'b0;
      transparent_q <= 1'b0;
      red_q         <= '0;
      green_q       <= '0;
      blue_q        <= '0;
    end else begin
      rgb_valid_q   <= pix_vld_c;
      transparent_q <= key_c;
      red_q         <= (pix_vld_c && !key_c) ? scale_ch(pal_red, mult_c)   : 4'd0;
      green_q       <= (pix_vld_c && !key_c) ? scale_ch(pal_green, mult_c) : 4'd0;
      blue_q        <= (pix_vld_c && !key_c) ? scale_ch(pal_blue, mult_c)  : 4'd0;
    end
  end

  assign pal_index   = pix_index;
  assign red         = red_q;
  assign green       = green_q;
  assign blue        = blue_q;
  assign rgb_valid   = rgb_valid_q;
  assign transparent = transparent_q;
  assign active      = active_q;
  assign fade_level  = level_q;
  assign done        = done_q;

endmodule

// File: tb/tb_end_screen_fade_ctrl.sv
// Self-checking bench for end_screen_fade_ctrl with a pixel scoreboard and a small palette ROM model.
module tb_end_screen_fade_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_tick, game_over, restart, pix_valid;
  logic [3:0] pix_index, pal_index;
  logic [3:0] pal_red, pal_green, pal_blue;
  logic [3:0] red, green, blue, fade_level;
  logic       rgb_valid, transparent, active, done;

  logic [11:0] rom [16];

  typedef struct packed {
    logic       v;
    logic       t;
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } pix_t;

  pix_t sb[$];

  int n_vec = 0;
  int n_err = 0;
  int unsigned exp_level = 0;
  logic        exp_active = 1'b0;

  end_screen_fade_ctrl #(.FADE_STEP_FRAMES(2), .HOLD_FRAMES(3)) dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .game_over(game_over),
    .restart(restart), .pix_valid(pix_valid), .pix_index(pix_index),
    .pal_index(pal_index), .pal_red(pal_red), .pal_green(pal_green),
    .pal_blue(pal_blue), .red(red), .green(green), .blue(blue),
    .rgb_valid(rgb_valid), .transparent(transparent), .active(active),
    .fade_level(fade_level), .done(done)
  );

  always #5 clk = ~clk;

  assign pal_red   = rom[pal_index][11:8];
  assign pal_green = rom[pal_index][7:4];
  assign pal_blue  = rom[pal_index][3:0];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tick(input logic with_restart);
    frame_tick = 1'b1;
    restart    = with_restart;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    restart    = 1'b0;
  endtask

  // Drives one pixel, predicts its output, then compares it one cycle later.
  task automatic pix(input logic [3:0] idx, input logic vld);
    pix_t        e;
    pix_t        got;
    logic [11:0] c;
    int unsigned sc;
    pix_index = idx;
    pix_valid = vld;
    #1;
    check("pal_index", pal_index, idx);
    c  = rom[idx];
    sc = exp_level + 1;
    e.v = vld & exp_active;
    e.t = 1'b0;
    e.r = e.v ? 4'((int'(c[11:8]) * sc) / 16) : 4'd0;
    e.g = e.v ? 4'((int'(c[7:4]) * sc) / 16) : 4'd0;
    e.b = e.v ? 4'((int'(c[3:0]) * sc) / 16) : 4'd0;
`ifdef TRANSPARENT_KEY_EN
    if (e.v && idx == 4'd0) begin
      e.t = 1'b1;
      e.r = 4'd0;
      e.g = 4'd0;
      e.b = 4'd0;
    end
`endif
    sb.push_back(e);
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
    got = sb.pop_front();
    check("rgb_valid", rgb_valid, got.v);
    check("transparent", transparent, got.t);
    check("red", red, got.r);
    check("green", green, got.g);
    check("blue", blue, got.b);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = {4'(i), 4'(15 - i), 4'(i ^ 5)};
    rom[0] = 12'hF0B;
    rom[5] = 12'hFFF;
    rom[6] = 12'hEFF;
    rst_n = 1'b0; frame_tick = 1'b0; game_over = 1'b0; restart = 1'b0;
    pix_valid = 1'b0; pix_index = 4'd0;

    // Reset state
    @(posedge clk);
    #1;
    check("rst_level", fade_level, 0);
    check("rst_active", active, 0);
    check("rst_done", done, 0);
    check("rst_rgb_valid", rgb_valid, 0);
    check("rst_transparent", transparent, 0);
    rst_n = 1'b1;
    cyc(2);
    check("idle_active", active, 0);
    pix(4'd5, 1'b1);

    // Fade-in with ignored restart and ignored game_over drop
    game_over = 1'b1;
    cyc(1);
    check("fadein_active", active, 1);
    exp_active = 1'b1;
    pix(4'd5, 1'b1);
    check("lvl0_red", red, 4'h0);
    for (int t = 1; t <= 30; t++) begin
      tick(t == 10);
      exp_level = t / 2;
      check("fade_in_lvl", fade_level, exp_level);
      if (t == 14) begin
        pix(4'd5, 1'b1);
        check("lvl7_red", red, 4'h7);
        check("lvl7_green", green, 4'h7);
        check("lvl7_blue", blue, 4'h7);
      end
      if (t == 20) begin
        game_over = 1'b0;
        cyc(1);
        game_over = 1'b1;
      end
    end

    // Level 15 pixels, including the key colour
    pix(4'd6, 1'b1);
    check("lvl15_red", red, 4'hE);
    check("lvl15_green", green, 4'hF);
    pix(4'd3, 1'b1);
    pix(4'd0, 1'b1);
`ifdef TRANSPARENT_KEY_EN
    check("key_transparent", transparent, 1);
    check("key_red", red, 4'h0);
`else
    check("key_transparent", transparent, 0);
    check("key_red", red, 4'hF);
    check("key_blue", blue, 4'hB);
`endif

    // Hold: restart ignored, three ticks then show
    tick(1'b0);
    restart = 1'b1;
    cyc(1);
    restart = 1'b0;
    tick(1'b0);
    tick(1'b0);
    cyc(2);
    check("hold_lvl", fade_level, 15);

    // Restart coincident with a tick: that tick is not counted
    tick(1'b1);
    check("show_exit_lvl", fade_level, 15);
    for (int t = 1; t <= 30; t++) begin
      tick(1'b0);
      exp_level = 15 - t / 2;
      check("fade_out_lvl", fade_level, exp_level);
      check("fade_out_done", done, (t == 30) ? 1 : 0);
    end
    check("done_active", active, 0);
    cyc(1);
    check("done_pulse_end", done, 0);
    exp_active = 1'b0;
    pix(4'd5, 1'b1);

    // DONE holds while game_over stays high
    restart = 1'b1;
    cyc(1);
    restart = 1'b0;
    cyc(3);
    check("done_hold_active", active, 0);
    check("done_hold_lvl", fade_level, 0);
    game_over = 1'b0;
    cyc(1);
    check("idle_again", active, 0);
    game_over = 1'b1;
    cyc(1);
    check("refade_active", active, 1);
    check("refade_lvl", fade_level, 0);
    exp_active = 1'b1;

    // Second run to level 9 in fade-out, then async reset
    for (int t = 1; t <= 30; t++) tick(1'b0);
    for (int t = 1; t <= 3; t++) tick(1'b0);
    cyc(2);
    restart = 1'b1;
    cyc(1);
    restart = 1'b0;
    for (int t = 1; t <= 12; t++) tick(1'b0);
    exp_level = 9;
    check("mid_out_lvl", fade_level, 9);
    pix(4'd5, 1'b1);
    check("lvl9_red", red, 4'h9);
    pix_valid = 1'b1;
    rst_n = 1'b0;
    #2;
    check("arst_level", fade_level, 0);
    check("arst_active", active, 0);
    check("arst_rgb_valid", rgb_valid, 0);
    check("arst_red", red, 0);
    check("arst_done", done, 0);
    pix_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(1);
    check("post_rst_active", active, 1);
    check("post_rst_lvl", fade_level, 0);
    tick(1'b0);
    tick(1'b0);
    check("post_rst_step", fade_level, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
